// File: rtl/ble_tx_pkg.sv
// Shared types and constants for the BLE command transmitter.
// Holds the FSM state encoding, parity modes and the default bit period.
package ble_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    localparam int unsigned PAR_NONE = 32'd0;
    localparam int unsigned PAR_EVEN = 32'd1;
    localparam int unsigned PAR_ODD  = 32'd2;

    localparam int unsigned BAUD_DIV_DEFAULT = 32'd2604;

    // Zero padding leaves the XOR unchanged, so any DATA_W up to 9 fits.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with registered status.
// A push while full is only accepted when a pop happens on the same edge.
module cmd_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              drop_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q;
    logic              push_ok_s, pop_ok_s;

    assign pop_ok_s  = pop_i && !empty_q;
    assign push_ok_s = push_i && (!full_q || pop_ok_s);
    assign drop_o    = push_i && full_q && !pop_ok_s;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

    // Occupancy next-state from the qualified push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == COUNT_FULL);
            empty_q <= (count_d == {CW{1'b0}});
        end
    end

    // Storage array; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/ble_cmd_tx.sv
// FIFO-buffered UART transmitter emulating the BLE command stream.
// Frames leave back-to-back: the STOP-end pop reloads the shifter directly.
module ble_cmd_tx
    import ble_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int BAUD_DIV  = int'(BAUD_DIV_DEFAULT),
    parameter int PARITY    = int'(PAR_NONE),
    parameter int STOP_BITS = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              TX,
    output logic              busy,
    output logic              tx_done,
    output logic              overflow
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NW = $clog2(DATA_W);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_W - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic          ODD_MODE  = (PARITY == int'(PAR_ODD));
    localparam logic          HAS_PAR   = (PARITY != int'(PAR_NONE));

    tx_state_e         state_q;
    logic [BW-1:0]     baud_q;
    logic [NW-1:0]     bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q, tx_q, busy_q, done_q, ovf_q;

    logic [DATA_W-1:0] head_s;
    logic              empty_s, drop_s, baud_end_s, frame_end_s, pop_s;

    cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (wr_en),
        .wr_data_i (wr_data),
        .pop_i     (pop_s),
        .rd_data_o (head_s),
        .drop_o    (drop_s),
        .full_o    (full),
        .empty_o   (empty_s),
        .count_o   (count)
    );

    assign baud_end_s  = (baud_q == BAUD_LAST);
    assign frame_end_s = (state_q == STOP) && baud_end_s && (bit_q == STOP_LAST);
    assign pop_s       = !empty_s && ((state_q == IDLE) || frame_end_s);

    assign empty    = empty_s;
    assign TX       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;
    assign overflow = ovf_q;

    // Frame sequencer: baud counter, bit counter, shifter and line driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= {NW{1'b0}};
            shift_q <= {DATA_W{1'b0}};
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovf_q  <= drop_s;
            if (pop_s) begin
                state_q <= START;
                baud_q  <= {BW{1'b0}};
                bit_q   <= {NW{1'b0}};
                shift_q <= head_s;
                par_q   <= calc_parity(9'(head_s), ODD_MODE);
                tx_q    <= 1'b0;
                busy_q  <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!pop_s) begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end_s) begin
                        state_q <= DATA;
                        baud_q  <= {BW{1'b0}};
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end_s) begin
                        baud_q <= {BW{1'b0}};
                        if (bit_q == DATA_LAST) begin
                            bit_q   <= {NW{1'b0}};
                            state_q <= HAS_PAR ? PAR : STOP;
                            tx_q    <= HAS_PAR ? par_q : 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                PAR: begin
                    if (baud_end_s) begin
                        state_q <= STOP;
                        baud_q  <= {BW{1'b0}};
                        bit_q   <= {NW{1'b0}};
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (frame_end_s) begin
                        done_q <= 1'b1;
                        if (!pop_s) begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else if (baud_end_s) begin
                        baud_q <= {BW{1'b0}};
                        bit_q  <= bit_q + 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_cmd_tx.sv
// Directed self-checking bench for ble_cmd_tx over five parameter sets:
// default 8N1, even/odd parity, 7-bit two-stop with parity, and a FIFO/reset set.
module tb_ble_cmd_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] wr_en = 5'b00000;
    logic [7:0] wr_d = 8'h00;

    logic       tx_w [5];
    logic       busy_w [5];
    logic       done_w [5];
    logic       full_w [5];
    logic       empty_w [5];
    logic       ovf_w [5];
    logic [2:0] cnt_w [5];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ble_cmd_tx u_def (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_d),
        .full(full_w[0]), .empty(empty_w[0]), .count(cnt_w[0]), .TX(tx_w[0]),
        .busy(busy_w[0]), .tx_done(done_w[0]), .overflow(ovf_w[0])
    );

    ble_cmd_tx #(.BAUD_DIV(16), .PARITY(1)) u_even (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_d),
        .full(full_w[1]), .empty(empty_w[1]), .count(cnt_w[1]), .TX(tx_w[1]),
        .busy(busy_w[1]), .tx_done(done_w[1]), .overflow(ovf_w[1])
    );

    ble_cmd_tx #(.BAUD_DIV(16), .PARITY(2)) u_odd (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wr_d),
        .full(full_w[2]), .empty(empty_w[2]), .count(cnt_w[2]), .TX(tx_w[2]),
        .busy(busy_w[2]), .tx_done(done_w[2]), .overflow(ovf_w[2])
    );

    ble_cmd_tx #(.DATA_W(7), .BAUD_DIV(16), .PARITY(1), .STOP_BITS(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[3]), .wr_data(wr_d[6:0]),
        .full(full_w[3]), .empty(empty_w[3]), .count(cnt_w[3]), .TX(tx_w[3]),
        .busy(busy_w[3]), .tx_done(done_w[3]), .overflow(ovf_w[3])
    );

    ble_cmd_tx #(.BAUD_DIV(16)) u_fifo (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[4]), .wr_data(wr_d),
        .full(full_w[4]), .empty(empty_w[4]), .count(cnt_w[4]), .TX(tx_w[4]),
        .busy(busy_w[4]), .tx_done(done_w[4]), .overflow(ovf_w[4])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(inout int pos, input int target);
        while (pos < target) begin
            tick();
            pos++;
        end
    endtask

    // Push one byte into an idle instance and confirm TX falls on the next edge.
    task automatic launch(input int s, input logic [7:0] data, input string tag);
        wr_en[s] = 1'b1;
        wr_d     = data;
        tick();
        check({tag, "_cnt1"}, 32'(cnt_w[s]), 32'd1);
        check({tag, "_idle_hi"}, 32'(tx_w[s]), 32'd1);
        wr_en[s] = 1'b0;
        tick();
        check({tag, "_start_lo"}, 32'(tx_w[s]), 32'd0);
        check({tag, "_busy"}, 32'(busy_w[s]), 32'd1);
        check({tag, "_cnt0"}, 32'(cnt_w[s]), 32'd0);
    endtask

    // Starting one tick into the frame, sample each bit mid-period, then the tx_done pulse.
    task automatic check_frame(input int s, input int baud, input int nbits,
                               input logic [15:0] bits, input string tag);
        int pos;
        pos = 0;
        for (int i = 0; i < nbits; i++) begin
            adv(pos, i * baud + baud / 2);
            check($sformatf("%s_bit%0d", tag, i), 32'(tx_w[s]), 32'(bits[i]));
        end
        adv(pos, nbits * baud - 1);
        check({tag, "_done_early"}, 32'(done_w[s]), 32'd0);
        adv(pos, nbits * baud);
        check({tag, "_done"}, 32'(done_w[s]), 32'd1);
        check({tag, "_busy_end"}, 32'(busy_w[s]), 32'd0);
        adv(pos, nbits * baud + 1);
        check({tag, "_done_once"}, 32'(done_w[s]), 32'd0);
        check({tag, "_tx_idle"}, 32'(tx_w[s]), 32'd1);
    endtask

    initial begin
        int pos;
        int lows;
        logic [4:0] b0;
        b0 = 5'b01011;

        repeat (3) tick();
        check("rst_tx", 32'(tx_w[0]), 32'd1);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_done", 32'(done_w[0]), 32'd0);
        check("rst_ovf", 32'(ovf_w[0]), 32'd0);
        check("rst_full", 32'(full_w[0]), 32'd0);
        check("rst_empty", 32'(empty_w[0]), 32'd1);
        check("rst_cnt", 32'(cnt_w[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        launch(0, 8'h67, "def");
        check_frame(0, 2604, 10, 16'({1'b1, 8'h67, 1'b0}), "def");

        launch(1, 8'h67, "even");
        check_frame(1, 16, 11, 16'({1'b1, 1'b1, 8'h67, 1'b0}), "even");

        launch(2, 8'h67, "odd");
        check_frame(2, 16, 11, 16'({1'b1, 1'b0, 8'h67, 1'b0}), "odd");

        launch(3, 8'h55, "s2");
        check_frame(3, 16, 11, 16'({2'b11, 1'b0, 7'h55, 1'b0}), "s2");

        // Five consecutive writes; the first pops at once so all fit.
        wr_en[4] = 1'b1;
        wr_d = 8'h67;
        tick();
        check("ff_cnt_e0", 32'(cnt_w[4]), 32'd1);
        wr_d = 8'h73;
        tick();
        pos = 0;
        check("ff_cnt_e1", 32'(cnt_w[4]), 32'd1);
        check("ff_start", 32'(tx_w[4]), 32'd0);
        wr_d = 8'h11;
        tick();
        pos++;
        check("ff_cnt_e2", 32'(cnt_w[4]), 32'd2);
        wr_d = 8'h22;
        tick();
        pos++;
        check("ff_cnt_e3", 32'(cnt_w[4]), 32'd3);
        wr_d = 8'h33;
        tick();
        pos++;
        check("ff_cnt_e4", 32'(cnt_w[4]), 32'd4);
        check("ff_full", 32'(full_w[4]), 32'd1);
        wr_d = 8'hEE;
        tick();
        pos++;
        check("ff_ovf", 32'(ovf_w[4]), 32'd1);
        check("ff_cnt_drop", 32'(cnt_w[4]), 32'd4);
        wr_en[4] = 1'b0;
        tick();
        pos++;
        check("ff_ovf_once", 32'(ovf_w[4]), 32'd0);
        adv(pos, 24);
        check("ff_f0_b0", 32'(tx_w[4]), 32'd1);

        for (int n = 1; n <= 6; n++) begin
            adv(pos, 160 * n - 1);
            check($sformatf("ff_done_early%0d", n), 32'(done_w[4]), 32'd0);
            if (n == 1) begin
                wr_en[4] = 1'b1;
                wr_d = 8'h44;
            end
            adv(pos, 160 * n);
            wr_en[4] = 1'b0;
            check($sformatf("ff_done%0d", n), 32'(done_w[4]), 32'd1);
            if (n == 1) begin
                check("ff_wr_pop_cnt", 32'(cnt_w[4]), 32'd4);
                check("ff_wr_pop_ovf", 32'(ovf_w[4]), 32'd0);
                check("ff_wr_pop_full", 32'(full_w[4]), 32'd1);
            end
            if (n < 6) begin
                check($sformatf("ff_gapless%0d", n), 32'(tx_w[4]), 32'd0);
                check($sformatf("ff_cnt%0d", n), 32'(cnt_w[4]), 32'(5 - n));
                adv(pos, 160 * n + 24);
                check($sformatf("ff_f%0d_b0", n), 32'(tx_w[4]), 32'(b0[n-1]));
            end else begin
                check("ff_end_tx", 32'(tx_w[4]), 32'd1);
                check("ff_end_busy", 32'(busy_w[4]), 32'd0);
                check("ff_end_empty", 32'(empty_w[4]), 32'd1);
            end
        end
        tick();

        // Reset in the middle of a data bit with a second byte still queued.
        wr_en[4] = 1'b1;
        wr_d = 8'hA5;
        tick();
        wr_d = 8'h5A;
        tick();
        wr_en[4] = 1'b0;
        repeat (40) tick();
        check("mid_busy", 32'(busy_w[4]), 32'd1);
        check("mid_cnt", 32'(cnt_w[4]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx_w[4]), 32'd1);
        check("arst_busy", 32'(busy_w[4]), 32'd0);
        check("arst_empty", 32'(empty_w[4]), 32'd1);
        check("arst_cnt", 32'(cnt_w[4]), 32'd0);
        tick();
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (tx_w[4] !== 1'b1 || busy_w[4] !== 1'b0) lows++;
        end
        check("post_rst_quiet", 32'(lows), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
